// File: rtl/nibble_add_pkg.sv
// -----------------------------------------------------------------------------
// nibble_add_pkg
// Shared types and constants for the nibble-serial adder controller.
//   NIBBLE_W : width of the adder slice reused on every pass
//   state_t  : controller states (IDLE / RUN / DONE), 2-bit encoding
// -----------------------------------------------------------------------------
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_ks_add4_cin.sv
// -----------------------------------------------------------------------------
// ks_add4_cin
// Combinational 4-bit Kogge-Stone adder slice with carry-in.
// Ports:
//   a, b  [3:0] in  : operand nibbles
//   cin         in  : carry into bit 0
//   s     [3:0] out : sum nibble
//   c4          out : carry out of bit 3
// -----------------------------------------------------------------------------
module ks_add4_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c4
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_g0;
    logic [3:0] w_g1;
    logic [3:0] w_p1;
    logic [3:0] w_g2;
    logic [3:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Carry-in acts as a generate at position -1; folding it into bit 0 lets
    // the two prefix stages cover the full 5-term span.
    assign w_g0 = {w_g[3:1], w_g[0] | (w_p[0] & cin)};

    // Prefix stage 1 (distance 1)
    assign w_g1[0] = w_g0[0];
    assign w_p1[0] = w_p[0];
    assign w_g1[1] = w_g0[1] | (w_p[1] & w_g0[0]);
    assign w_p1[1] = w_p[1] & w_p[0];
    assign w_g1[2] = w_g0[2] | (w_p[2] & w_g0[1]);
    assign w_p1[2] = w_p[2] & w_p[1];
    assign w_g1[3] = w_g0[3] | (w_p[3] & w_g0[2]);
    assign w_p1[3] = w_p[3] & w_p[2];

    // Prefix stage 2 (distance 2)
    assign w_g2[0] = w_g1[0];
    assign w_g2[1] = w_g1[1];
    assign w_g2[2] = w_g1[2] | (w_p1[2] & w_g1[0]);
    assign w_g2[3] = w_g1[3] | (w_p1[3] & w_g1[1]);

    assign w_c = {w_g2[2:0], cin};
    assign s   = w_p ^ w_c;
    assign c4  = w_g2[3];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
// WIDTH-bit adder built by running one 4-bit Kogge-Stone slice over the
// operands, least-significant nibble first, with the carry registered between
// passes. Operands arrive on a valid/ready handshake; sum and carry-out leave
// on a second valid/ready handshake.
//
// Optional build macro: SUBTRACT_EN adds input 'sub'; when set at accept the
// block computes a - b (b inverted, carry-in forced to 1, cout = NOT borrow).
//
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, cin           : operands and carry into nibble 0
//   sub                 : subtract select (SUBTRACT_EN builds only)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, cout           : registered result and carry out of the MSB
//   busy                : high while an operation is in RUN or DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble per cycle through the slice
// DONE  | result held until the consumer takes it
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    generate
        if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_cin_load;
    logic [3:0]         w_s4;
    logic               w_c4;
    logic [WIDTH+3:0]   w_sum_cat;
    logic [WIDTH-1:0]   w_sum_sh_nxt;

`ifdef SUBTRACT_EN
    assign w_b_load   = sub ? ~b : b;
    assign w_cin_load = sub ? 1'b1 : cin;
`else
    assign w_b_load   = b;
    assign w_cin_load = cin;
`endif

    ks_add4_cin u_slice (
        .a   (r_a_sh[NIBBLE_W-1:0]),
        .b   (r_b_sh[NIBBLE_W-1:0]),
        .cin (r_carry),
        .s   (w_s4),
        .c4  (w_c4)
    );

    // New nibble enters at the top; after NIBBLES passes nibble 0 sits at the
    // bottom. The concatenation keeps this valid even when WIDTH == 4.
    assign w_sum_cat    = {w_s4, r_sum_sh};
    assign w_sum_sh_nxt = w_sum_cat[WIDTH+3:4];

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_a_sh   <= a;
            r_b_sh   <= w_b_load;
            r_carry  <= w_cin_load;
        end else if (r_state == RUN) begin
            r_a_sh   <= r_a_sh >> NIBBLE_W;
            r_b_sh   <= r_b_sh >> NIBBLE_W;
            r_sum_sh <= w_sum_sh_nxt;
            r_carry  <= w_c4;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_sum_sh_nxt;
                r_cout <= w_c4;
            end
        end
    end

endmodule
